if_fetch_buffer: RTL and testbench



---
 rtl/if_fetch_buffer_pkg.sv | 17 +
 rtl/if_fetch_buffer_if.sv | 20 ++
 rtl/if_fetch_buffer_sync_fifo.sv | 64 ++++++
 rtl/if_fetch_buffer.sv | 103 ++++++++++
 tb/tb_if_fetch_buffer.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_buffer_pkg.sv
// Shared fetch-buffer types: decode-queue entry, in-flight request tag, and fixed constants.
package if_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        epoch;
    } fetch_tag_t;

endpackage

// File: rtl/if_fetch_buffer_if.sv
// Instruction-memory request/response bus between the fetch buffer (master) and imem (slave).
interface if_fetch_buffer_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

endinterface

// File: rtl/if_fetch_buffer_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push into a full FIFO is accepted when a pop happens
// in the same cycle. Clear empties it at the next edge and discards any same-cycle push.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int              PW       = $clog2(DEPTH) + 1;
    localparam int              IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]   IDX_MASK = PW'(DEPTH - 1);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [IW-1:0]    wr_idx, rd_idx;
    logic             do_push, do_pop;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (count == PW'(DEPTH));
        wr_idx   = IW'(wr_ptr_q & IDX_MASK);
        rd_idx   = IW'(rd_ptr_q & IDX_MASK);
        pop_data = mem_q[rd_idx];
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; only the pointers decide what is live.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_idx] <= push_data;
    end

endmodule

// File: rtl/if_fetch_buffer.sv
// Fetch buffer: issues imem reads at pc_f, queues returned instructions for decode, kills stale
// fetches on flush_d with a 1-bit epoch. Define IF_FETCH_BYPASS_EN to forward responses to decode.
module if_fetch_buffer #(
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUT   = 2,
    parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc_f,
    output logic              stall_f,
    input  logic              flush_d,
    if_fetch_buffer_if.master imem,
    input  logic              stall_d,
    output logic              valid_d,
    output logic [31:0]       instr_d,
    output logic [31:0]       pc_d,
    output logic [31:0]       pc_plus4_d
);

    import if_pkg::*;

    localparam int QCW = $clog2(DEPTH) + 1;
    localparam int OCW = $clog2(MAX_OUT) + 1;

    fetch_tag_t   tag_push_data, tag_head;
    fetch_entry_t q_push_data, q_head, dec_entry;
    logic         tag_full, tag_empty, tag_pop;
    logic         q_full, q_empty, q_push, q_pop;
    logic         req_fire, rsp_current, dec_valid;
    logic         epoch_q, epoch_d, flush_prev_q, flush_prev_d;
    logic [OCW-1:0] outstanding;
    logic [QCW-1:0] q_count;

    assign imem.imem_req_addr = pc_f;

    always_comb begin
        // Credit for the queue slot is reserved at issue, so a later response can always land.
        imem.imem_req_valid = !reset && !flush_d && !tag_full
                              && ((int'(q_count) + int'(outstanding)) < DEPTH);
        req_fire      = imem.imem_req_valid && imem.imem_req_ready;
        stall_f       = !req_fire;
        tag_push_data = '{pc: pc_f, epoch: epoch_q};
        tag_pop       = imem.imem_rsp_valid && !tag_empty;
        rsp_current   = tag_pop && !flush_d && (tag_head.epoch == epoch_q);
        q_push_data   = '{pc: tag_head.pc, instr: imem.imem_rsp_data};
        q_pop         = !q_empty && !stall_d && !flush_d;
`ifdef IF_FETCH_BYPASS_EN
        dec_valid = !q_empty || rsp_current;
        dec_entry = q_empty ? q_push_data : q_head;
        q_push    = rsp_current && !(q_empty && !stall_d) && (!q_full || q_pop);
`else
        dec_valid = !q_empty;
        dec_entry = q_head;
        q_push    = rsp_current && (!q_full || q_pop);
`endif
        valid_d    = dec_valid;
        instr_d    = dec_valid ? dec_entry.instr : NOP_INSTR;
        pc_d       = dec_valid ? dec_entry.pc : RESET_VECTOR;
        pc_plus4_d = pc_d + 32'd4;
        // One toggle per redirect: a flush held for several cycles must not alias the epoch back.
        epoch_d      = epoch_q ^ (flush_d && !flush_prev_q);
        flush_prev_d = flush_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            epoch_q      <= 1'b0;
            flush_prev_q <= 1'b0;
        end else begin
            epoch_q      <= epoch_d;
            flush_prev_q <= flush_prev_d;
        end
    end

    sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_instr_q (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush_d),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .pop_data  (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    // Never cleared: entries issued before a flush drain out as stale responses.
    sync_fifo #(.WIDTH(33), .DEPTH(MAX_OUT)) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (1'b0),
        .push      (req_fire),
        .push_data (tag_push_data),
        .pop       (tag_pop),
        .pop_data  (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (outstanding)
    );

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Randomized bench for if_fetch_buffer: an imem/PC environment model drives the DUT while a
// scoreboard of live fetches (per redirect generation) predicts every decode-side output.
module tb_if_fetch_buffer;

    localparam int          DEPTH   = 4;
    localparam int          MAX_OUT = 2;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_f;
    logic        stall_f, flush_d, stall_d, valid_d;
    logic [31:0] instr_d, pc_d, pc_plus4_d;

    if_fetch_buffer_if imem_bus ();

    if_fetch_buffer #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .NOP_INSTR(NOP)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_f       (pc_f),
        .stall_f    (stall_f),
        .flush_d    (flush_d),
        .imem       (imem_bus),
        .stall_d    (stall_d),
        .valid_d    (valid_d),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pc_plus4_d (pc_plus4_d)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] data; int gen; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

    req_t inflight[$];   // requests accepted by imem, not yet answered
    ent_t live_q[$];     // answered, current-generation fetches awaiting decode

    int   tests = 0, fails = 0, consumed = 0;
    int   gen = 0;
    logic flush_prev_m = 1'b0, cyc_hs = 1'b0;
    int   p_ready, p_rsp, p_stall, p_flush;
    logic [31:0] redirect_pc;

    // monitor scratch
    int   out_n, live_n;
    logic exp_rv, hs, cur_rsp, has_head;
    ent_t head;
    req_t r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit no_stale();
        foreach (inflight[i]) if (inflight[i].gen != gen) return 1'b0;
        return 1'b1;
    endfunction

    // Monitor: compare this cycle's outputs, then advance the model to the coming edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                chk1("rst_req_valid", imem_bus.imem_req_valid, 1'b0);
                chk1("rst_stall_f", stall_f, 1'b1);
                inflight.delete();
                live_q.delete();
                gen = 0;
                flush_prev_m = 1'b0;
                cyc_hs = 1'b0;
            end else begin
                out_n  = inflight.size();
                live_n = live_q.size();
                exp_rv = !flush_d && (out_n < MAX_OUT) && (live_n + out_n < DEPTH);
                chk1("req_valid", imem_bus.imem_req_valid, exp_rv);
                hs = imem_bus.imem_req_valid && imem_bus.imem_req_ready;
                chk1("stall_f", stall_f, !hs);
                chk("req_addr", imem_bus.imem_req_addr, pc_f);
                cur_rsp  = imem_bus.imem_rsp_valid && !flush_d && (out_n > 0) && (inflight[0].gen == gen);
                has_head = (live_n > 0);
                if (has_head) head = live_q[0];
`ifdef IF_FETCH_BYPASS_EN
                if (!has_head && cur_rsp) begin
                    has_head = 1'b1;
                    head = '{pc: inflight[0].pc, data: inflight[0].data};
                end
`endif
                chk1("valid_d", valid_d, has_head);
                if (has_head) begin
                    chk("pc_d", pc_d, head.pc);
                    chk("instr_d", instr_d, head.data);
                    chk("pc_plus4_d", pc_plus4_d, head.pc + 32'd4);
                end else begin
                    chk("idle_instr_nop", instr_d, NOP);
                    chk("idle_pc_zero", pc_d, 32'h0);
                    chk("idle_pc_plus4", pc_plus4_d, 32'h4);
                end
                if (imem_bus.imem_rsp_valid && out_n > 0) begin
                    r = inflight.pop_front();
                    if (cur_rsp) live_q.push_back('{pc: r.pc, data: r.data});
                end
                if (has_head && !stall_d && !flush_d) begin
                    void'(live_q.pop_front());
                    consumed++;
                end
                if (hs) inflight.push_back('{pc: pc_f, data: $urandom(), gen: gen});
                if (flush_d) begin
                    live_q.delete();
                    if (!flush_prev_m) gen++;
                end
                flush_prev_m = flush_d;
                cyc_hs = hs;
            end
        end
    end

    task automatic set_knobs(input int rdy, input int rsp, input int stl, input int fl);
        p_ready = rdy; p_rsp = rsp; p_stall = stl; p_flush = fl;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (flush_d) pc_f = redirect_pc;
            else if (cyc_hs) pc_f = pc_f + 32'd4;
            stall_d = (int'($urandom_range(99)) < p_stall);
            imem_bus.imem_req_ready = (int'($urandom_range(99)) < p_ready);
            if (flush_d) begin
                flush_d = ($urandom_range(3) == 0);
            end else if (no_stale() && int'($urandom_range(99)) < p_flush) begin
                flush_d = 1'b1;
                redirect_pc = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            end
            if (inflight.size() > 0 && int'($urandom_range(99)) < p_rsp) begin
                imem_bus.imem_rsp_valid = 1'b1;
                imem_bus.imem_rsp_data  = inflight[0].data;
            end else begin
                imem_bus.imem_rsp_valid = 1'b0;
                imem_bus.imem_rsp_data  = $urandom();
            end
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        reset = 1'b1;
        flush_d = 1'b0;
        stall_d = 1'b0;
        pc_f = 32'h0;
        imem_bus.imem_req_ready = 1'b0;
        imem_bus.imem_rsp_valid = 1'b0;
        repeat (n - 1) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        pc_f = 32'h0;
        flush_d = 1'b0;
        stall_d = 1'b0;
        redirect_pc = 32'h100;
        imem_bus.imem_req_ready = 1'b0;
        imem_bus.imem_rsp_valid = 1'b0;
        imem_bus.imem_rsp_data  = 32'h0;
        set_knobs(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        set_knobs(100, 100, 0, 0);   run_cycles(20);   // streaming, 1-cycle imem
        set_knobs(100, 100, 100, 0); run_cycles(8);    // decode stalled, queue fills
        set_knobs(100, 100, 0, 0);   run_cycles(10);
        set_knobs(0, 100, 0, 0);     run_cycles(3);    // imem not ready
        set_knobs(100, 100, 0, 0);   run_cycles(10);
        set_knobs(100, 100, 10, 8);  run_cycles(300);  // redirects with requests in flight
        set_knobs(80, 60, 30, 0);    run_cycles(400);  // full-queue pop/push/issue overlap
        set_knobs(70, 50, 30, 4);    run_cycles(1500);
        do_reset(2);                                   // mid-stream reset
        set_knobs(100, 100, 0, 0);   run_cycles(20);
        set_knobs(100, 40, 60, 0);   run_cycles(30);
        do_reset(1);
        set_knobs(60, 70, 40, 5);    run_cycles(1000);

        tests++;
        if (consumed < 200) begin
            fails++;
            $display("FAIL throughput: consumed %0d instructions, required at least 200", consumed);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
